// File: rtl/xor_ks_pkg.sv
// Shared definitions for the XOR keystream tile: FSM states, pin-bit
// positions on the bidirectional bus and default LFSR constants.
package xor_ks_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEYLD = 2'd1,
    ST_READY = 2'd2
  } ks_state_e;

  // uio_in control bits
  localparam int UIO_VALID_IN  = 0;
  localparam int UIO_LOAD      = 1;
  localparam int UIO_MODE      = 2;
  localparam int UIO_CLEAR     = 3;

  // uio_out status bits
  localparam int UIO_VALID_OUT = 4;
  localparam int UIO_KEY_READY = 5;
  localparam int UIO_MODE_OUT  = 6;

  // Only the three status bits are driven outward.
  localparam logic [7:0] UIO_OE_MASK = 8'h70;

  // Maximal-length 16-bit Galois mask (right-shift form) and the
  // non-zero seed that replaces an all-zero key.
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h0001;

  // Places the registered status flags at their uio_out positions;
  // every other bit of the byte stays 0.
  function automatic logic [7:0] pack_status(input logic vld,
                                             input logic rdy,
                                             input logic mode);
    logic [7:0] b;
    b                = 8'h00;
    b[UIO_VALID_OUT] = vld;
    b[UIO_KEY_READY] = rdy;
    b[UIO_MODE_OUT]  = mode;
    return b;
  endfunction

endpackage

// File: rtl/tt_um_xor_keystream_lfsr_step8.sv
// Combinational byte-advance of a right-shift Galois LFSR: maps the current
// state to the state eight single-bit steps later, so one keystream byte
// is consumed per clock.
module lfsr_step8 #(
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(16'hB400)
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  // Unrolled eight Galois steps: shift right, fold TAPS in when a 1 drops out.
  always_comb begin
    logic [LFSR_W-1:0] s;
    s = state_i;
    for (int i = 0; i < 8; i++) begin
      if (s[0]) begin
        s = (s >> 1) ^ TAPS;
      end else begin
        s = s >> 1;
      end
    end
    state_o = s;
  end

endmodule

// File: rtl/tt_um_xor_keystream.sv
// TinyTapeout user top: byte-serial stream scrambler. A key of LFSR_W bits
// is shifted in LSB-byte first over ui_in; afterwards each valid byte is
// XORed with key byte 0 (mode 0) or with the low byte of a Galois LFSR
// keystream (mode 1) and presented one cycle later on uo_out.
// LFSR_W must be a multiple of 8 and at least 16.
module tt_um_xor_keystream
  import xor_ks_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned    NBYTES   = LFSR_W / 8;
  localparam int unsigned    CNT_W    = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  // Control decode; ena and the upper control nibble carry no function.
  logic valid_in, load_in, mode_in, clear_in;
  logic unused_in;

  assign valid_in  = uio_in[UIO_VALID_IN];
  assign load_in   = uio_in[UIO_LOAD];
  assign mode_in   = uio_in[UIO_MODE];
  assign clear_in  = uio_in[UIO_CLEAR];
  assign unused_in = &{1'b0, ena, uio_in[7:4]};

  ks_state_e          state_q;
  logic [LFSR_W-1:0]  key_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         uo_q;
  logic               vld_q;
  logic               rdy_q;
  logic               mode_q;

  logic [LFSR_W-1:0]  key_d;
  logic [LFSR_W-1:0]  lfsr_seed_d;
  logic [LFSR_W-1:0]  lfsr_adv;
  logic [7:0]         ks_byte;

  // Key with the current ui_in byte dropped into the slot cnt_q points at,
  // and the LFSR start value derived from it (zero key falls back to SEED).
  always_comb begin
    key_d                        = key_q;
    key_d[{cnt_q, 3'b000} +: 8]  = ui_in;
    lfsr_seed_d                  = (key_d == '0) ? SEED : key_d;
  end

  lfsr_step8 #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_step8 (
    .state_i (lfsr_q),
    .state_o (lfsr_adv)
  );

  // Keystream byte chosen by the per-byte mode bit.
  assign ks_byte = mode_in ? lfsr_q[7:0] : key_q[7:0];

  // FSM, key/LFSR registers and registered outputs; clear beats load beats valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      uo_q    <= 8'h00;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (clear_in) begin
        state_q <= ST_IDLE;
        key_q   <= '0;
        lfsr_q  <= '0;
        cnt_q   <= '0;
        rdy_q   <= 1'b0;
      end else if (load_in) begin
        unique case (state_q)
          ST_KEYLD: begin
            key_q <= key_d;
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_READY;
              lfsr_q  <= lfsr_seed_d;
              cnt_q   <= '0;
              rdy_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            // IDLE or READY: (re)start a key load with byte 0.
            key_q[7:0] <= ui_in;
            cnt_q      <= CNT_W'(1);
            state_q    <= ST_KEYLD;
            rdy_q      <= 1'b0;
          end
        endcase
      end else if (valid_in && (state_q == ST_READY)) begin
        uo_q   <= ui_in ^ ks_byte;
        vld_q  <= 1'b1;
        mode_q <= mode_in;
        if (mode_in) begin
          lfsr_q <= lfsr_adv;
        end
      end
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = pack_status(vld_q, rdy_q, mode_q);
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_xor_keystream.sv
// Bench for tt_um_xor_keystream: directed scenarios with hand-computed
// expectations followed by a randomized control/data stream, all checked
// every cycle against a queue-based behavioural model of the scrambler.
module tb_tt_um_xor_keystream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_err    = 0;

  tt_um_xor_keystream dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = no key, 1 = collecting key bytes, 2 = key usable
  int         m_phase;
  logic [7:0] kq[$];
  logic [15:0] m_key, m_lfsr;
  logic [7:0] m_uo;
  bit         m_vld, m_rdy, m_mode;

  function automatic logic [15:0] adv8(input logic [15:0] s);
    for (int i = 0; i < 8; i++) s = (s & 16'h1) != 0 ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  task automatic model_reset();
    m_phase = 0; kq.delete(); m_key = 0; m_lfsr = 0;
    m_uo = 0; m_vld = 0; m_rdy = 0; m_mode = 0;
  endtask

  task automatic model_step(input logic [7:0] ui, input bit vin, input bit ld,
                            input bit md, input bit clr);
    m_vld = 0;
    if (clr) begin
      m_phase = 0; kq.delete(); m_key = 0; m_lfsr = 0; m_rdy = 0;
    end else if (ld) begin
      if (m_phase != 1) kq.delete();
      kq.push_back(ui);
      m_phase = 1; m_rdy = 0;
      if (kq.size() == 2) begin
        m_key  = {kq[1], kq[0]};
        m_lfsr = (m_key == 16'h0) ? 16'h0001 : m_key;
        m_phase = 2; m_rdy = 1;
      end
    end else if (vin && m_phase == 2) begin
      m_vld = 1; m_mode = md;
      if (md) begin
        m_uo = ui ^ m_lfsr[7:0];
        m_lfsr = adv8(m_lfsr);
      end else begin
        m_uo = ui ^ m_key[7:0];
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("uo_out", {8'h00, uo_out}, {8'h00, m_uo});
    chk("uio_out", {8'h00, uio_out}, {8'h00, 1'b0, m_mode, m_rdy, m_vld, 4'h0});
  endtask

  // Entered and left at a falling edge; drives one cycle and checks after it.
  task automatic cycle(input logic [7:0] ui, input bit vin, input bit ld,
                       input bit md, input bit clr);
    ui_in  = ui;
    uio_in = {4'($urandom_range(0, 15)), clr, md, ld, vin};
    model_step(ui, vin, ld, md, clr);
    @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  // Asynchronous reset dropped mid-cycle, held across one edge.
  task automatic mid_reset();
    ui_in = 8'h00; uio_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_uo", {8'h00, uo_out}, 16'h0000);
    chk("async_rst_uio", {8'h00, uio_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    chk("model_adv8_ACE1", adv8(16'hACE1), 16'hC2C4);
    chk("model_adv8_seed", adv8(16'h0001), 16'h0168);

    // Reset held low with valid pulses: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ui_in = 8'hA5; uio_in = 8'h05;
      @(posedge clk); #1;
      chk("rst_uo", {8'h00, uo_out}, 16'h0000);
      chk("rst_uio", {8'h00, uio_out}, 16'h0000);
      chk("rst_oe", {8'h00, uio_oe}, 16'h0070);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h5A, 1, 0, 0, 0);
    chk("idle_no_valid", {15'h0, uio_out[4]}, 16'h0000);

    // Mode 0, key 0x1234
    cycle(8'h34, 0, 1, 0, 0);
    cycle(8'h12, 0, 1, 0, 0);
    chk("key_ready", {15'h0, uio_out[5]}, 16'h0001);
    cycle(8'hFF, 1, 0, 0, 0);
    chk("m0_byte0", {8'h00, uo_out}, 16'h00CB);
    chk("m0_valid", {15'h0, uio_out[4]}, 16'h0001);
    cycle(8'h00, 1, 0, 0, 0);
    chk("m0_byte1", {8'h00, uo_out}, 16'h0034);
    cycle(8'h00, 0, 0, 0, 0);
    chk("valid_one_cycle", {15'h0, uio_out[4]}, 16'h0000);

    // Mode 1, key 0xACE1
    cycle(8'hE1, 0, 1, 0, 0);
    cycle(8'hAC, 0, 1, 0, 0);
    cycle(8'h00, 1, 0, 1, 0);
    chk("m1_byte0", {8'h00, uo_out}, 16'h00E1);
    cycle(8'h00, 1, 0, 1, 0);
    chk("m1_byte1", {8'h00, uo_out}, 16'h00C4);
    chk("m1_mode_out", {15'h0, uio_out[6]}, 16'h0001);

    // Zero key uses the seed
    cycle(8'h00, 0, 1, 0, 0);
    cycle(8'h00, 0, 1, 0, 0);
    cycle(8'h00, 1, 0, 1, 0);
    chk("seed_byte0", {8'h00, uo_out}, 16'h0001);
    cycle(8'h00, 1, 0, 1, 0);
    chk("seed_byte1", {8'h00, uo_out}, 16'h0068);
    for (int i = 0; i < 20; i++) cycle(8'h00, 1, 0, 1, 0);

    // clear + load + valid in READY
    cycle(8'h55, 1, 1, 0, 1);
    chk("clr_all_valid", {15'h0, uio_out[4]}, 16'h0000);
    chk("clr_all_ready", {15'h0, uio_out[5]}, 16'h0000);
    cycle(8'h34, 0, 1, 0, 0);
    cycle(8'h12, 0, 1, 0, 0);
    // load + valid: reload wins
    cycle(8'h77, 1, 1, 0, 0);
    chk("ld_vld_valid", {15'h0, uio_out[4]}, 16'h0000);
    chk("ld_vld_ready", {15'h0, uio_out[5]}, 16'h0000);
    cycle(8'h12, 0, 1, 0, 0);
    cycle(8'hFF, 1, 0, 0, 0);
    chk("reload_byte", {8'h00, uo_out}, 16'h0088);

    // Reset in the middle of a key load
    cycle(8'h34, 0, 1, 0, 0);
    mid_reset();
    cycle(8'h12, 0, 1, 0, 0);
    chk("midrst_not_ready", {15'h0, uio_out[5]}, 16'h0000);
    cycle(8'h34, 0, 1, 0, 0);
    chk("midrst_ready", {15'h0, uio_out[5]}, 16'h0001);
    cycle(8'hFF, 1, 0, 0, 0);
    chk("midrst_byte", {8'h00, uo_out}, 16'h00ED);

    // Randomized stream
    for (int i = 0; i < 3000; i++) begin
      bit clr, ld, vin, md;
      logic [7:0] ui;
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      vin = ($urandom_range(0, 1) == 1);
      md  = ($urandom_range(0, 1) == 1);
      ui  = 8'($urandom_range(0, 255));
      if (ld && $urandom_range(0, 3) == 0) ui = 8'h00;
      if ($urandom_range(0, 299) == 0) mid_reset();
      else cycle(ui, vin, ld, md, clr);
    end
    chk("end_oe", {8'h00, uio_oe}, 16'h0070);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_xor_keystream.md
# tt_um_xor_keystream

Parametrised successor to the single-byte XOR tile: a clocked, byte-serial stream scrambler for the TinyTapeout user slot. A key is loaded over `ui_in` and each valid input byte is XORed with either a fixed key byte or an LFSR keystream. The result is registered onto `uo_out` with a valid flag. Sits directly as the user-project top level, behind the standard TT pin wrapper.

## Interface
- `LFSR_W`, default 16: key/LFSR width in bits. Must be a multiple of 8, at least 16.
- `TAPS`, default 16'hB400: Galois feedback mask (right-shift form). The default is maximal-length for 16 bits.
- `SEED`, default 16'h0001: substituted whenever a loaded key is all-zero.
- `clk  in  1`: the single clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `ena  in  1`: always 1; unused.
- `ui_in  in  8`: data byte, or key byte during loading.
- `uio_in  in  8`: controls.
  - [0] `valid_in`
  - [1] `load`
  - [2] `mode` (0 = fixed key, 1 = LFSR)
  - [3] `clear`
  - [7:4] ignored
- `uo_out  out  8`: registered scrambled byte.
- `uio_out  out  8`:
  - [4] `valid_out`
  - [5] `key_ready`
  - [6] registered `mode` of the last output byte
  - all other bits 0
- `uio_oe  out  8`: constant 8'h70.

## Operation
- FSM states: IDLE, KEYLD, READY.
- IDLE → KEYLD: on `load`. Capture `ui_in` into key byte 0 (LSB first) and set byte counter to 1.
- KEYLD, on each `load`:
  - Capture `ui_in` into key byte[cnt] and increment cnt.
  - On the final byte (cnt = LFSR_W/8−1), go to READY.
  - Cycles with `load` low hold state.
- Entering READY:
  - LFSR state := assembled key, or `SEED` if the key is zero.
  - `key_ready` = 1.
- READY with `valid_in`:
  - `mode`=0: `uo_out` := `ui_in` ^ key[7:0]. LFSR unchanged.
  - `mode`=1: `uo_out` := `ui_in` ^ lfsr[7:0]. The LFSR then advances 8 Galois steps.
  - One Galois step: lsb = s[0]; s = s>>1; if lsb, s ^= TAPS.
- `load` in READY restarts loading:
  - Capture byte 0, go to KEYLD.
  - `key_ready` drops to 0.
- `clear` in any state: go to IDLE; key, LFSR and counter are zeroed.
- Priority on the same cycle: `clear` > `load` > `valid_in`.
- `valid_in` outside READY is ignored: no output, no LFSR step.
- `mode` is sampled per byte, so it may change between bytes. LFSR state persists across mode-0 bytes.

## Timing
- Reset values:
  - state IDLE
  - `uo_out` = 0
  - `valid_out` = 0, `key_ready` = 0
  - `uio_out` = 0
  - key and LFSR = 0
- Latency: 1 cycle. A byte with `valid_in` at edge N appears on `uo_out` with `valid_out` = 1 after edge N.
  - `valid_out` is high for exactly one cycle per accepted byte.
  - `uo_out` holds its last value otherwise.
- Throughput: one byte per cycle, back-to-back.
- `key_ready` rises in the cycle after the final key byte's edge. `valid_in` is accepted from that cycle on.
- Asynchronous reset mid-stream: all registers clear immediately and any in-flight byte is lost.

## Structure
- Package `xor_ks_pkg`:
  - FSM state enum
  - `uio_in`/`uio_out` bit-index constants
  - `UIO_OE_MASK` (8'h70)
  - default `TAPS`/`SEED`
- One sub-module, `lfsr_step8`: combinational, parametrised by `LFSR_W`/`TAPS`, maps state to the state after 8 steps.
- The top level holds the FSM, key register, counter and output registers.

## Test plan
- Reset: hold `rst_n` low. Expect `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'h70. `valid_in` pulses give no `valid_out` in IDLE.
- Mode 0:
  - Load 8'h34 then 8'h12; expect `key_ready` = 1.
  - `ui_in` = 8'hFF, `valid_in`, `mode`=0 → next cycle `uo_out` = 8'hCB, `valid_out` = 1.
  - A second byte 8'h00 → 8'h34.
- Mode 1:
  - Load 8'hE1 then 8'hAC.
  - Two back-to-back 8'h00 bytes → 8'hE1 then 8'hC4. Internal LFSR goes 16'hACE1 → 16'hC2C4 after the first byte.
- Zero key: load 8'h00, 8'h00; stream 8'h00 in mode 1 → first output 8'h01 (SEED), and the LFSR never sticks at zero.
- Simultaneous controls:
  - `clear`+`load`+`valid_in` in READY → IDLE, no `valid_out`, `key_ready` = 0.
  - `load`+`valid_in` → reload wins, no output.
- Reset mid-load: assert `rst_n` low after one key byte, then release. Expect IDLE; a full two-byte reload is required before `key_ready`.
